// File: rtl/hash_ctrl_pkg.sv
// Shared types for the cuckoo hash controller: request opcodes, response
// status codes and controller FSM states.
package hash_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_NOTHING = 2'b00,
    OP_READ    = 2'b01,
    OP_WRITE   = 2'b10,
    OP_DELETE  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_OK                  = 3'd0,
    ST_NOT_FOUND           = 3'd1,
    ST_NO_DELETION_TARGET  = 3'd2,
    ST_KEY_ALREADY_PRESENT = 3'd3,
    ST_NO_WRITE_SPACE      = 3'd4
  } status_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_CMP  = 2'd2,
    S_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/hash_table_slot_select.sv
// Per-table hit / free evaluation of the candidate slots read for the current
// key; the uniqueness invariant allows an OR-mux over the hit vector.
module hash_table_slot_select #(
  parameter int KEY_WIDTH        = 8,
  parameter int DATA_WIDTH       = 16,
  parameter int NUMBER_OF_TABLES = 3
) (
  input  logic [NUMBER_OF_TABLES-1:0]                          i_rd_valid,
  input  logic [NUMBER_OF_TABLES-1:0][KEY_WIDTH+DATA_WIDTH-1:0] i_rd_keys_data,
  input  logic [KEY_WIDTH-1:0]                                 i_cur_key,
  output logic [NUMBER_OF_TABLES-1:0]                          o_hit,
  output logic                                                 o_any_hit,
  output logic [DATA_WIDTH-1:0]                                o_hit_data,
  output logic [NUMBER_OF_TABLES-1:0]                          o_free_oh,
  output logic                                                 o_any_free
);

  localparam int KD = KEY_WIDTH + DATA_WIDTH;

  logic [NUMBER_OF_TABLES-1:0] w_free;

  // Key compare per table and OR-combined payload of the hitting table
  always_comb begin
    o_hit      = '0;
    o_hit_data = '0;
    for (int t = 0; t < NUMBER_OF_TABLES; t++) begin
      o_hit[t]   = i_rd_valid[t] & (i_rd_keys_data[t][KD-1 -: KEY_WIDTH] == i_cur_key);
      o_hit_data = o_hit_data | (i_rd_keys_data[t][DATA_WIDTH-1:0] & {DATA_WIDTH{o_hit[t]}});
    end
  end

  // x & -x isolates the lowest-index free table
  assign w_free     = ~i_rd_valid;
  assign o_free_oh  = w_free & (~w_free + NUMBER_OF_TABLES'(1));
  assign o_any_free = |w_free;
  assign o_any_hit  = |o_hit;

endmodule

// File: rtl/hash_table_cuckoo_fsm.sv
// Handshaked cuckoo hash controller: serialises read/write/delete and performs
// bounded multi-hop displacement, returning the last victim when it gives up.
module hash_table_cuckoo_fsm
  import hash_ctrl_pkg::*;
#(
  parameter int KEY_WIDTH           = 8,
  parameter int DATA_WIDTH          = 16,
  parameter int NUMBER_OF_TABLES    = 3,
  parameter int HASH_TABLE_MAX_SIZE = 4,
  parameter int MAX_KICKS           = 4,
  parameter int KICK_CNT_WIDTH      = $clog2(MAX_KICKS + 1)
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  req_valid_i,
  output logic                                                  req_ready_o,
  input  logic [1:0]                                            req_op_i,
  input  logic [KEY_WIDTH-1:0]                                  req_key_i,
  input  logic [DATA_WIDTH-1:0]                                 req_data_i,
  output logic [KEY_WIDTH-1:0]                                  hash_key_o,
  input  logic [NUMBER_OF_TABLES-1:0][HASH_TABLE_MAX_SIZE-1:0]  hash_adr_i,
  output logic                                                  mem_rd_en_o,
  output logic [NUMBER_OF_TABLES-1:0][HASH_TABLE_MAX_SIZE-1:0]  mem_rd_adr_o,
  input  logic [NUMBER_OF_TABLES-1:0][KEY_WIDTH+DATA_WIDTH-1:0] mem_rd_keys_data_i,
  input  logic [NUMBER_OF_TABLES-1:0]                           mem_rd_valid_i,
  output logic [NUMBER_OF_TABLES-1:0]                           mem_wr_en_o,
  output logic [NUMBER_OF_TABLES-1:0][HASH_TABLE_MAX_SIZE-1:0]  mem_wr_adr_o,
  output logic [NUMBER_OF_TABLES-1:0][KEY_WIDTH+DATA_WIDTH-1:0] mem_wr_keys_data_o,
  output logic [NUMBER_OF_TABLES-1:0]                           mem_wr_valid_flag_o,
  output logic                                                  resp_valid_o,
  input  logic                                                  resp_ready_i,
  output logic [2:0]                                            resp_status_o,
  output logic [KEY_WIDTH-1:0]                                  resp_key_o,
  output logic [DATA_WIDTH-1:0]                                 resp_data_o,
  output logic [KICK_CNT_WIDTH-1:0]                             resp_kicks_o
);

  localparam int VW = (NUMBER_OF_TABLES > 1) ? $clog2(NUMBER_OF_TABLES) : 1;
  localparam logic [KICK_CNT_WIDTH-1:0] MAX_K = KICK_CNT_WIDTH'(MAX_KICKS);
  localparam logic [VW-1:0] LAST_T = VW'(NUMBER_OF_TABLES - 1);

  state_t                                               r_state, w_state_nxt;
  op_t                                                  r_op, w_op_nxt;
  status_t                                              r_status, w_status_nxt;
  logic [KEY_WIDTH-1:0]                                 r_cur_key, w_cur_key_nxt;
  logic [DATA_WIDTH-1:0]                                r_cur_data, w_cur_data_nxt;
  logic [DATA_WIDTH-1:0]                                r_resp_data, w_resp_data_nxt;
  logic [KICK_CNT_WIDTH-1:0]                            r_kick_cnt, w_kick_cnt_nxt;
  logic [VW-1:0]                                        r_victim, w_victim_nxt;
  logic [NUMBER_OF_TABLES-1:0][HASH_TABLE_MAX_SIZE-1:0] r_cur_adr, w_cur_adr_nxt;

  logic [NUMBER_OF_TABLES-1:0] w_hit, w_free_oh;
  logic                        w_any_hit, w_any_free;
  logic [DATA_WIDTH-1:0]       w_hit_data;

  hash_table_slot_select #(
    .KEY_WIDTH       (KEY_WIDTH),
    .DATA_WIDTH      (DATA_WIDTH),
    .NUMBER_OF_TABLES(NUMBER_OF_TABLES)
  ) u_slot_select (
    .i_rd_valid    (mem_rd_valid_i),
    .i_rd_keys_data(mem_rd_keys_data_i),
    .i_cur_key     (r_cur_key),
    .o_hit         (w_hit),
    .o_any_hit     (w_any_hit),
    .o_hit_data    (w_hit_data),
    .o_free_oh     (w_free_oh),
    .o_any_free    (w_any_free)
  );

  // State and operand registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= OP_NOTHING;
      r_status    <= ST_OK;
      r_cur_key   <= '0;
      r_cur_data  <= '0;
      r_resp_data <= '0;
      r_kick_cnt  <= '0;
      r_victim    <= '0;
      r_cur_adr   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_op        <= w_op_nxt;
      r_status    <= w_status_nxt;
      r_cur_key   <= w_cur_key_nxt;
      r_cur_data  <= w_cur_data_nxt;
      r_resp_data <= w_resp_data_nxt;
      r_kick_cnt  <= w_kick_cnt_nxt;
      r_victim    <= w_victim_nxt;
      r_cur_adr   <= w_cur_adr_nxt;
    end
  end

  // Next-state and output decode; everything is forced low while rst_n is low
  always_comb begin
    w_state_nxt         = r_state;
    w_op_nxt            = r_op;
    w_status_nxt        = r_status;
    w_cur_key_nxt       = r_cur_key;
    w_cur_data_nxt      = r_cur_data;
    w_resp_data_nxt     = r_resp_data;
    w_kick_cnt_nxt      = r_kick_cnt;
    w_victim_nxt        = r_victim;
    w_cur_adr_nxt       = r_cur_adr;
    req_ready_o         = 1'b0;
    hash_key_o          = '0;
    mem_rd_en_o         = 1'b0;
    mem_rd_adr_o        = '0;
    mem_wr_en_o         = '0;
    mem_wr_adr_o        = '0;
    mem_wr_keys_data_o  = '0;
    mem_wr_valid_flag_o = '0;
    resp_valid_o        = 1'b0;
    resp_status_o       = 3'd0;
    resp_key_o          = '0;
    resp_data_o         = '0;
    resp_kicks_o        = '0;
    if (!rst_n) begin
      w_state_nxt = S_IDLE;
    end else begin
      hash_key_o = r_cur_key;
      case (r_state)
        S_IDLE: begin
          req_ready_o = 1'b1;
          if (req_valid_i && (req_op_i != OP_NOTHING)) begin
            w_op_nxt       = op_t'(req_op_i);
            w_cur_key_nxt  = req_key_i;
            w_cur_data_nxt = req_data_i;
            w_kick_cnt_nxt = '0;
            w_victim_nxt   = '0;
            w_state_nxt    = S_READ;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_READ: begin
          mem_rd_en_o   = 1'b1;
          mem_rd_adr_o  = hash_adr_i;
          w_cur_adr_nxt = hash_adr_i;
          w_state_nxt   = S_CMP;
        end
        S_CMP: begin
          mem_wr_adr_o       = r_cur_adr;
          mem_wr_keys_data_o = {NUMBER_OF_TABLES{r_cur_key, r_cur_data}};
          w_state_nxt        = S_RESP;
          w_resp_data_nxt    = r_cur_data;
          case (r_op)
            OP_READ: begin
              w_status_nxt    = w_any_hit ? ST_OK : ST_NOT_FOUND;
              w_resp_data_nxt = w_any_hit ? w_hit_data : '0;
            end
            OP_DELETE: begin
              mem_wr_en_o  = w_hit;
              w_status_nxt = w_any_hit ? ST_OK : ST_NO_DELETION_TARGET;
            end
            OP_WRITE: begin
              // Displaced keys are unique, so only the host key needs a hit check
              if ((r_kick_cnt == '0) && w_any_hit) begin
                w_status_nxt = ST_KEY_ALREADY_PRESENT;
              end else if (w_any_free) begin
                mem_wr_en_o         = w_free_oh;
                mem_wr_valid_flag_o = w_free_oh;
                w_status_nxt        = ST_OK;
              end else if (r_kick_cnt < MAX_K) begin
                mem_wr_en_o[r_victim]         = 1'b1;
                mem_wr_valid_flag_o[r_victim] = 1'b1;
                {w_cur_key_nxt, w_cur_data_nxt} = mem_rd_keys_data_i[r_victim];
                w_kick_cnt_nxt = r_kick_cnt + KICK_CNT_WIDTH'(1);
                w_victim_nxt   = (r_victim == LAST_T) ? '0 : r_victim + VW'(1);
                w_state_nxt    = S_READ;
              end else begin
                w_status_nxt = ST_NO_WRITE_SPACE;
              end
            end
            default: begin
              w_state_nxt = S_IDLE;
            end
          endcase
        end
        S_RESP: begin
          resp_valid_o  = 1'b1;
          resp_status_o = r_status;
          resp_key_o    = r_cur_key;
          resp_data_o   = r_resp_data;
          resp_kicks_o  = r_kick_cnt;
          w_state_nxt   = resp_ready_i ? S_IDLE : S_RESP;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hash_table_cuckoo_fsm.sv
// Randomised and directed bench for hash_table_cuckoo_fsm with a bench-owned
// table memory and a behavioural cuckoo reference model.
module tb_hash_table_cuckoo_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, req_valid_i, req_ready_o, resp_ready_i, resp_valid_o, mem_rd_en_o;
  logic [1:0]       req_op_i;
  logic [7:0]       req_key_i, hash_key_o, resp_key_o;
  logic [15:0]      req_data_i, resp_data_o;
  logic [2:0][3:0]  hash_adr_i, mem_rd_adr_o, mem_wr_adr_o;
  logic [2:0][23:0] mem_rd_keys_data_i, mem_wr_keys_data_o;
  logic [2:0]       mem_rd_valid_i, mem_wr_en_o, mem_wr_valid_flag_o, resp_status_o, resp_kicks_o;

  hash_table_cuckoo_fsm dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_key_i(req_key_i), .req_data_i(req_data_i),
    .hash_key_o(hash_key_o), .hash_adr_i(hash_adr_i),
    .mem_rd_en_o(mem_rd_en_o), .mem_rd_adr_o(mem_rd_adr_o),
    .mem_rd_keys_data_i(mem_rd_keys_data_i), .mem_rd_valid_i(mem_rd_valid_i),
    .mem_wr_en_o(mem_wr_en_o), .mem_wr_adr_o(mem_wr_adr_o),
    .mem_wr_keys_data_o(mem_wr_keys_data_o), .mem_wr_valid_flag_o(mem_wr_valid_flag_o),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_status_o(resp_status_o),
    .resp_key_o(resp_key_o), .resp_data_o(resp_data_o), .resp_kicks_o(resp_kicks_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int hash_mode = 0;

  logic [142:0] all_out;
  assign all_out = {req_ready_o, hash_key_o, mem_rd_en_o, mem_rd_adr_o, mem_wr_en_o, mem_wr_adr_o,
                    mem_wr_keys_data_o, mem_wr_valid_flag_o, resp_valid_o, resp_status_o,
                    resp_key_o, resp_data_o, resp_kicks_o};

  // External hash units: mode 0 spreads keys, mode 1 maps every key to slot 5
  function automatic logic [3:0] hfun(input logic [7:0] k, input int t, input int mode);
    if (mode == 1) return 4'd5;
    case (t)
      0:       return k[3:0];
      1:       return k[7:4];
      default: return k[3:0] ^ k[7:4];
    endcase
  endfunction

  always_comb begin
    for (int t = 0; t < 3; t++) hash_adr_i[t] = hfun(hash_key_o, t, hash_mode);
  end

  // Bench-owned table memories (1-cycle read latency) plus a backdoor port
  logic        mem_v  [3][16];
  logic [23:0] mem_kd [3][16];
  logic        bd_clr = 1'b0, bd_en = 1'b0;
  int          bd_t, bd_a;
  logic [23:0] bd_kd;

  always @(posedge clk) begin
    if (bd_clr) begin
      for (int t = 0; t < 3; t++) for (int a = 0; a < 16; a++) mem_v[t][a] <= 1'b0;
    end else if (bd_en) begin
      mem_v[bd_t][bd_a]  <= 1'b1;
      mem_kd[bd_t][bd_a] <= bd_kd;
    end else begin
      for (int t = 0; t < 3; t++) if (mem_wr_en_o[t]) begin
        mem_v[t][mem_wr_adr_o[t]]  <= mem_wr_valid_flag_o[t];
        mem_kd[t][mem_wr_adr_o[t]] <= mem_wr_keys_data_o[t];
      end
    end
    for (int t = 0; t < 3; t++) if (mem_rd_en_o) begin
      mem_rd_valid_i[t]     <= mem_v[t][mem_rd_adr_o[t]];
      mem_rd_keys_data_i[t] <= mem_kd[t][mem_rd_adr_o[t]];
    end
  end

  // Reference tables
  bit          ref_v  [3][16];
  logic [23:0] ref_kd [3][16];

  function automatic int mem_diff();
    int d = 0;
    for (int t = 0; t < 3; t++) for (int a = 0; a < 16; a++) begin
      if (mem_v[t][a] !== ref_v[t][a]) d++;
      else if (ref_v[t][a] && (mem_kd[t][a] !== ref_kd[t][a])) d++;
    end
    return d;
  endfunction

  task automatic clear_tables();
    bd_clr = 1'b1;
    @(posedge clk); #1;
    bd_clr = 1'b0;
    for (int t = 0; t < 3; t++) for (int a = 0; a < 16; a++) ref_v[t][a] = 1'b0;
  endtask

  task automatic preload(input int t, input int a, input logic [23:0] kd);
    bd_en = 1'b1; bd_t = t; bd_a = a; bd_kd = kd;
    @(posedge clk); #1;
    bd_en = 1'b0;
    ref_v[t][a] = 1'b1; ref_kd[t][a] = kd;
  endtask

  // Cuckoo rules applied directly to the reference tables
  task automatic model_op(input logic [1:0] op, input logic [7:0] key, input logic [15:0] data,
                          output logic [2:0] st, output int kicks,
                          output logic [7:0] rkey, output logic [15:0] rdata);
    logic [23:0] cur, tmp;
    int hit_t, free_t, v, a;
    bit done;
    cur = {key, data}; kicks = 0; rkey = key; rdata = 16'h0; st = 3'd0; hit_t = -1;
    for (int t = 0; t < 3; t++) begin
      a = hfun(key, t, hash_mode);
      if (ref_v[t][a] && ref_kd[t][a][23:16] == key) hit_t = t;
    end
    case (op)
      2'b01: if (hit_t >= 0) rdata = ref_kd[hit_t][hfun(key, hit_t, hash_mode)][15:0]; else st = 3'd1;
      2'b11: if (hit_t >= 0) ref_v[hit_t][hfun(key, hit_t, hash_mode)] = 1'b0; else st = 3'd2;
      default: begin
        if (hit_t >= 0) st = 3'd3;
        else begin
          done = 1'b0;
          while (!done) begin
            free_t = -1;
            for (int t = 2; t >= 0; t--) if (!ref_v[t][hfun(cur[23:16], t, hash_mode)]) free_t = t;
            if (free_t >= 0) begin
              a = hfun(cur[23:16], free_t, hash_mode);
              ref_v[free_t][a] = 1'b1; ref_kd[free_t][a] = cur; done = 1'b1;
            end else if (kicks < 4) begin
              v = kicks % 3; a = hfun(cur[23:16], v, hash_mode);
              tmp = ref_kd[v][a]; ref_kd[v][a] = cur; cur = tmp; kicks++;
            end else begin
              st = 3'd4; rkey = cur[23:16]; rdata = cur[15:0]; done = 1'b1;
            end
          end
        end
      end
    endcase
  endtask

  // One host transaction; lat counts cycles from the accept edge to resp_valid
  task automatic do_op(input logic [1:0] op, input logic [7:0] key, input logic [15:0] data,
                       output logic [2:0] st, output logic [2:0] kk, output logic [7:0] rkey,
                       output logic [15:0] rdata, output int lat, output bit wr_seen);
    int w = 0;
    req_valid_i = 1'b1; req_op_i = op; req_key_i = key; req_data_i = data;
    while (!req_ready_o && w < 20) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    req_valid_i = 1'b0; req_op_i = 2'b00;
    lat = 1; wr_seen = 1'b0;
    while (!resp_valid_o && lat < 40) begin
      wr_seen = wr_seen | (mem_wr_en_o != 3'b000);
      @(posedge clk); #1; lat++;
    end
    st = resp_status_o; kk = resp_kicks_o; rkey = resp_key_o; rdata = resp_data_o;
    resp_ready_i = 1'b1;
    @(posedge clk); #1;
    resp_ready_i = 1'b0;
  endtask

  logic [2:0]  o_st, o_k, m_st;
  logic [7:0]  o_key, m_key;
  logic [15:0] o_data, m_data;
  int          o_lat, m_k;
  bit          o_wr;

  task automatic test_reset();
    rst_n = 1'b0; req_valid_i = 1'b0; req_op_i = 2'b00; req_key_i = 8'h0; req_data_i = 16'h0;
    resp_ready_i = 1'b0; bd_clr = 1'b1;
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if (all_out !== 143'h0) begin n_fail++; $display("FAIL reset_outputs got %h want 0", all_out); end
    bd_clr = 1'b0; rst_n = 1'b1; #1;
    n_checks++;
    if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", req_ready_o); end
    for (int t = 0; t < 3; t++) for (int a = 0; a < 16; a++) ref_v[t][a] = 1'b0;
  endtask

  task automatic test_basic();
    hash_mode = 0; clear_tables();
    model_op(2'b10, 8'h11, 16'hBEEF, m_st, m_k, m_key, m_data);
    do_op(2'b10, 8'h11, 16'hBEEF, o_st, o_k, o_key, o_data, o_lat, o_wr);
    n_checks++;
    if (o_st !== 3'd0 || o_k !== 3'd0 || o_st !== m_st) begin
      n_fail++; $display("FAIL basic_write status %0d kicks %0d want 0/0", o_st, o_k);
    end
    n_checks++;
    if (mem_v[0][1] !== 1'b1 || mem_kd[0][1] !== 24'h11BEEF) begin
      n_fail++; $display("FAIL basic_table0 got v=%b kd=%h want 1/11beef", mem_v[0][1], mem_kd[0][1]);
    end
    model_op(2'b01, 8'h11, 16'h0, m_st, m_k, m_key, m_data);
    do_op(2'b01, 8'h11, 16'h0, o_st, o_k, o_key, o_data, o_lat, o_wr);
    n_checks++;
    if (o_st !== m_st || o_data !== 16'hBEEF || o_lat != 3) begin
      n_fail++; $display("FAIL basic_read st %0d data %h lat %0d want 0/beef/3", o_st, o_data, o_lat);
    end
  endtask

  task automatic test_errors();
    do_op(2'b10, 8'h11, 16'h1234, o_st, o_k, o_key, o_data, o_lat, o_wr);
    n_checks++;
    if (o_st !== 3'd3 || o_wr !== 1'b0) begin
      n_fail++; $display("FAIL dup_write st %0d wr %b want 3/0", o_st, o_wr);
    end
    do_op(2'b11, 8'h22, 16'h0, o_st, o_k, o_key, o_data, o_lat, o_wr);
    n_checks++;
    if (o_st !== 3'd2) begin n_fail++; $display("FAIL delete_absent st %0d want 2", o_st); end
    do_op(2'b01, 8'h22, 16'h0, o_st, o_k, o_key, o_data, o_lat, o_wr);
    n_checks++;
    if (o_st !== 3'd1) begin n_fail++; $display("FAIL read_absent st %0d want 1", o_st); end
    n_checks++;
    if (mem_diff() != 0) begin n_fail++; $display("FAIL errors_mem got %0d diffs want 0", mem_diff()); end
  endtask

  task automatic test_one_kick();
    hash_mode = 0; clear_tables();
    preload(0, 3, 24'h43_0A0A); preload(1, 3, 24'h38_0B0B); preload(2, 0, 24'h55_0C0C);
    model_op(2'b10, 8'h33, 16'h3333, m_st, m_k, m_key, m_data);
    do_op(2'b10, 8'h33, 16'h3333, o_st, o_k, o_key, o_data, o_lat, o_wr);
    n_checks++;
    if (o_st !== 3'd0 || o_k !== 3'd1 || o_lat != 5 || m_k != 1) begin
      n_fail++; $display("FAIL one_kick st %0d kicks %0d lat %0d want 0/1/5", o_st, o_k, o_lat);
    end
    n_checks++;
    if (mem_diff() != 0 || mem_kd[0][3] !== 24'h33_3333 || mem_kd[1][4] !== 24'h43_0A0A) begin
      n_fail++; $display("FAIL one_kick_mem diffs %0d t0=%h t1=%h", mem_diff(), mem_kd[0][3], mem_kd[1][4]);
    end
  endtask

  task automatic test_full();
    hash_mode = 1; clear_tables();
    preload(0, 5, 24'hA1_0001); preload(1, 5, 24'hA2_0002); preload(2, 5, 24'hA3_0003);
    model_op(2'b10, 8'hB4, 16'h1234, m_st, m_k, m_key, m_data);
    do_op(2'b10, 8'hB4, 16'h1234, o_st, o_k, o_key, o_data, o_lat, o_wr);
    n_checks++;
    if (o_st !== 3'd4 || o_k !== 3'd4 || o_lat != 11) begin
      n_fail++; $display("FAIL full_status st %0d kicks %0d lat %0d want 4/4/11", o_st, o_k, o_lat);
    end
    n_checks++;
    if (o_key !== m_key || o_data !== m_data) begin
      n_fail++; $display("FAIL full_victim got %h/%h want %h/%h", o_key, o_data, m_key, m_data);
    end
    n_checks++;
    if (mem_diff() != 0) begin n_fail++; $display("FAIL full_mem got %0d diffs want 0", mem_diff()); end
  endtask

  task automatic test_backpressure();
    logic [29:0] snap;
    int w = 0;
    hash_mode = 0; clear_tables();
    model_op(2'b10, 8'h11, 16'hBEEF, m_st, m_k, m_key, m_data);
    do_op(2'b10, 8'h11, 16'hBEEF, o_st, o_k, o_key, o_data, o_lat, o_wr);
    req_valid_i = 1'b1; req_op_i = 2'b01; req_key_i = 8'h11;
    @(posedge clk); #1;
    req_valid_i = 1'b0; req_op_i = 2'b00;
    while (!resp_valid_o && w < 20) begin @(posedge clk); #1; w++; end
    snap = {resp_status_o, resp_key_o, resp_data_o, resp_kicks_o};
    n_checks++;
    if (snap !== {3'd0, 8'h11, 16'hBEEF, 3'd0}) begin
      n_fail++; $display("FAIL bp_resp got %h want %h", snap, {3'd0, 8'h11, 16'hBEEF, 3'd0});
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (!resp_valid_o || req_ready_o || ({resp_status_o, resp_key_o, resp_data_o, resp_kicks_o} !== snap)) begin
        n_fail++; $display("FAIL bp_hold cycle %0d valid %b ready %b", c, resp_valid_o, req_ready_o);
      end
    end
    resp_ready_i = 1'b1;
    @(posedge clk); #1;
    resp_ready_i = 1'b0;
    n_checks++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL bp_release ready %b valid %b want 1/0", req_ready_o, resp_valid_o);
    end
  endtask

  task automatic test_reset_mid();
    hash_mode = 1; clear_tables();
    preload(0, 5, 24'hA1_0001); preload(1, 5, 24'hA2_0002); preload(2, 5, 24'hA3_0003);
    req_valid_i = 1'b1; req_op_i = 2'b10; req_key_i = 8'hB4; req_data_i = 16'h1234;
    @(posedge clk); #1;
    req_valid_i = 1'b0; req_op_i = 2'b00;
    @(posedge clk); #1;
    n_checks++;
    if (mem_wr_en_o !== 3'b001) begin n_fail++; $display("FAIL mid_first_kick wr_en %b want 001", mem_wr_en_o); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_wr_en_o !== 3'b000) begin n_fail++; $display("FAIL mid_abort_wr wr_en %b want 000", mem_wr_en_o); end
    @(posedge clk); #1;
    n_checks++;
    if (all_out !== 143'h0) begin n_fail++; $display("FAIL mid_reset_outputs got %h want 0", all_out); end
    rst_n = 1'b1; #1;
    ref_kd[0][5] = 24'hB4_1234;
    n_checks++;
    if (mem_diff() != 0 || req_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL mid_mem diffs %0d ready %b want 0/1", mem_diff(), req_ready_o);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [24];
    logic [1:0] op;
    logic [7:0] key;
    logic [15:0] data;
    int r;
    hash_mode = 0; clear_tables();
    for (int i = 0; i < 24; i++) pool[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      op = (r < 5) ? 2'b10 : (r < 8) ? 2'b01 : 2'b11;
      key = pool[$urandom_range(0, 23)];
      data = 16'($urandom);
      model_op(op, key, data, m_st, m_k, m_key, m_data);
      do_op(op, key, data, o_st, o_k, o_key, o_data, o_lat, o_wr);
      n_checks++;
      if (o_st !== m_st || o_k !== 3'(m_k) || o_lat != 3 + 2 * m_k) begin
        n_fail++;
        $display("FAIL rand_resp op %0d key %h got st %0d k %0d lat %0d want %0d/%0d/%0d",
                 op, key, o_st, o_k, o_lat, m_st, m_k, 3 + 2 * m_k);
      end
      if ((op == 2'b01 && m_st == 3'd0) || m_st == 3'd4) begin
        n_checks++;
        if (o_data !== m_data || (m_st == 3'd4 && o_key !== m_key)) begin
          n_fail++; $display("FAIL rand_data got %h/%h want %h/%h", o_key, o_data, m_key, m_data);
        end
      end
      n_checks++;
      if (mem_diff() != 0) begin n_fail++; $display("FAIL rand_mem op %0d got %0d diffs want 0", i, mem_diff()); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_one_kick();
    test_full();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
